pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Registered program-counter unit for the RISC-V core: owns the PC register and computes its next value.
//  Next-value sources: sequential, PC-relative (JAL/branch) or register-relative (JALR).
//  Adds stall hold, a parametrised halt-address self-loop, a misaligned-target trap and a retired-step counter.
//  Sits between decode/branch-compare (inputs) and the instruction-memory address port (pc).
// PARAMETERS
//  XLEN         32          datapath width of PC, offset, rs1_data
//  RESET_VECTOR 0           PC value after reset and after resume
//  HALT_EN      1           1 = enable the halt-address self-loop
//  HALT_ADDR    32'd48      PC at which a sequential fetch parks the core
//  TRAP_VECTOR  32'h100     PC loaded on misaligned-target trap
//  CNT_W        32          width of instret counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  stall        in   1      hold PC this cycle (RUN only)
//  sel          in   2      00 seq, 01 pc+offset, 10 rs1+offset, 11 treated as 00
//  branch_taken in   1      conditional branch resolved taken
//  offset       in   XLEN   sign-extended immediate
//  rs1_data     in   XLEN   JALR base register value
//  resume       in   1      leave HALT/TRAP and restart at RESET_VECTOR
//  pc           out  XLEN   current PC (registered)
//  next_pc      out  XLEN   value pc takes at next edge (combinational)
//  halted       out  1      state == HALT (registered)
//  trap         out  1      state == TRAP (registered)
//  trap_pc      out  XLEN   PC of instruction whose target faulted
//  instret      out  CNT_W  count of PC advances in RUN; saturates at all-ones
// BEHAVIOUR
//  Reset (async, any time, mid-operation included):
//   pc=RESET_VECTOR, state=RUN, halted=0, trap=0, trap_pc=0, instret=0.
//  Target priority: sel==01 -> pc+offset; sel==10 -> (rs1_data+offset)&~1;
//   else branch_taken -> pc+offset; else pc+4.
//  Target arithmetic: all sums modulo 2^XLEN (wrap, no overflow flag).
//  misalign = target[1:0]!=0, evaluated after bit0 clear.
//  FSM states RUN, HALT, TRAP; all transitions on rising clk.
//  RUN, priority order:
//   1. stall: pc, state, instret held; misalign and halt not evaluated.
//   2. halt: HALT_EN && pc==HALT_ADDR && sel!=01/10 && !branch_taken -> state HALT, pc held.
//   3. misalign: pc<=TRAP_VECTOR, trap_pc<=pc, state TRAP.
//   4. else pc<=target, instret+=1 (saturating).
//  HALT / TRAP: pc held; stall, sel, branch ignored.
//   resume=1 -> pc<=RESET_VECTOR, state RUN, trap_pc and instret kept.
//  resume in RUN is ignored; rst beats resume.
//  next_pc mirrors exactly the value the register loads (held pc on stall/halt/trap,
//   TRAP_VECTOR on misalign, RESET_VECTOR on resume), zero latency from inputs.
//  Latency: input change -> pc update at the next rising edge (1 cycle).
//  halted/trap reflect state from the same edge that changes it.
// STRUCTURE
//  pc_pkg: sel encodings (PC_SEQ, PC_REL, PC_RS1), state enum (ST_RUN/ST_HALT/ST_TRAP).
//  Sub-module pc_target_calc: combinational target mux, bit0 clear, misalign flag.
//  pc_gen: FSM, PC/trap_pc/instret registers, next_pc mux.
// TESTING
//  rst pulse mid-run at pc=0x20 -> pc=0, instret=0, halted=0 immediately (async).
//  seq from 0 with stall high at pc=8 for 3 cycles -> pc 0,4,8,8,8,8,12; instret=3 at pc=12.
//  pc=0x10, sel=10, rs1=0x41, offset=3 -> pc=0x44; sel=01, offset=-8 at pc=0x44 -> pc=0x3C.
//  pc=0x0C, sel=01, offset=6 -> trap=1, pc=0x100, trap_pc=0x0C; resume -> pc=0, trap=0.
//  Reach pc=48 seq -> halted=1, pc stays 48 for 10 cycles; branch_taken at 48 with offset=8 -> pc=56, no halt.
//  pc=0xFFFFFFFC seq (HALT_EN=0) -> pc wraps to 0; instret preset near max saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC source select and FSM states.
package pc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_RS1 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational jump/branch target selection with JALR bit0 clear and alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] target,
  output logic            misalign,
  output logic            seq_fetch
);

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] rs1_sum;

  assign rel_sum = pc + offset;
  assign rs1_sum = rs1_data + offset;

  // NOTE: combinational blocks assign every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    target    = pc + XLEN'(4);
    seq_fetch = 1'b0;
    case (sel)
      PC_REL:  target = rel_sum;
      PC_RS1:  target = {rs1_sum[XLEN-1:1], 1'b0};
      default: begin
        if (branch_taken) target = rel_sum;
        else              seq_fetch = 1'b1;
      end
    endcase
  end

  assign misalign = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// Program-counter register, RUN/HALT/TRAP control, trap PC capture and retired-step counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              HALT_EN      = 1,
  parameter logic [XLEN-1:0] HALT_ADDR    = 32'd48,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  offset,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  next_pc,
  output logic             halted,
  output logic             trap,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] instret
);

  state_e          state;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            seq_fetch;
  logic            halt_hit;
  logic            go_halt;
  logic            go_trap;
  logic            advance;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .pc           (pc),
    .sel          (sel),
    .branch_taken (branch_taken),
    .offset       (offset),
    .rs1_data     (rs1_data),
    .target       (target),
    .misalign     (misalign),
    .seq_fetch    (seq_fetch)
  );

  assign halt_hit = (HALT_EN != 0) && (pc == HALT_ADDR) && seq_fetch;

  // next_pc is exactly what the register loads, so the fetch port can use it a cycle early.
  always_comb begin
    next_pc = pc;
    go_halt = 1'b0;
    go_trap = 1'b0;
    advance = 1'b0;
    case (state)
      ST_RUN: begin
        if (!stall) begin
          if (halt_hit) begin
            go_halt = 1'b1;
          end else if (misalign) begin
            go_trap = 1'b1;
            next_pc = TRAP_VECTOR;
          end else begin
            advance = 1'b1;
            next_pc = target;
          end
        end
      end
      default: begin
        if (resume) next_pc = RESET_VECTOR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      pc      <= RESET_VECTOR;
      halted  <= 1'b0;
      trap    <= 1'b0;
      trap_pc <= '0;
      instret <= '0;
    end else begin
      pc <= next_pc;
      case (state)
        ST_RUN: begin
          if (go_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (go_trap) begin
            state   <= ST_TRAP;
            trap    <= 1'b1;
            trap_pc <= pc;
          end else if (advance && (instret != '1)) begin
            instret <= instret + CNT_W'(1);
          end
        end
        default: begin
          if (resume) begin
            state  <= ST_RUN;
            halted <= 1'b0;
            trap   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: default instance plus a wrap/saturation instance.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  sel;
  logic        branch_taken;
  logic [31:0] offset;
  logic [31:0] rs1_data;
  logic        resume;
  logic [31:0] pc, next_pc, trap_pc;
  logic        halted, trap;
  logic [31:0] instret;

  logic        rst_b;
  logic [31:0] pc_b, next_pc_b, trap_pc_b;
  logic        halted_b, trap_b;
  logic [2:0]  instret_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk (clk), .rst (rst), .stall (stall), .sel (sel), .branch_taken (branch_taken),
    .offset (offset), .rs1_data (rs1_data), .resume (resume), .pc (pc), .next_pc (next_pc),
    .halted (halted), .trap (trap), .trap_pc (trap_pc), .instret (instret)
  );

  pc_gen #(.RESET_VECTOR(32'hFFFF_FFF0), .HALT_EN(0), .CNT_W(3)) dut_b (
    .clk (clk), .rst (rst_b), .stall (1'b0), .sel (2'b00), .branch_taken (1'b0),
    .offset (32'd0), .rs1_data (32'd0), .resume (1'b0), .pc (pc_b), .next_pc (next_pc_b),
    .halted (halted_b), .trap (trap_b), .trap_pc (trap_pc_b), .instret (instret_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1; stall = 1'b0; sel = 2'b00; branch_taken = 1'b0;
    offset = '0; rs1_data = '0; resume = 1'b0;
    #12;
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_trap", trap, 0);
    check("rst_trap_pc", trap_pc, 0);
    check("rst_instret", instret, 0);
    check("rst_b_pc", pc_b, 32'hFFFF_FFF0);
    rst = 1'b0;

    // Sequential fetch with a 3-cycle stall at pc=8.
    step(); check("seq_4", pc, 4);
    step(); check("seq_8", pc, 8);
    stall = 1'b1;
    #1 check("stall_next_pc", next_pc, 8);
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", pc, 8);
    end
    stall = 1'b0;
    #1 check("unstall_next_pc", next_pc, 12);
    step(); check("seq_12", pc, 12);
    check("instret_3", instret, 3);

    // JALR with bit0 clear, then JAL backwards.
    step(); check("seq_10", pc, 32'h10);
    sel = 2'b10; rs1_data = 32'h41; offset = 32'd3;
    #1 check("jalr_next_pc", next_pc, 32'h44);
    step(); check("jalr_pc", pc, 32'h44);
    sel = 2'b01; offset = 32'hFFFF_FFF8;
    step(); check("jal_back_pc", pc, 32'h3C);
    check("instret_6", instret, 6);
    offset = 32'hFFFF_FFE4;
    step(); check("jal_to_20", pc, 32'h20);
    sel = 2'b00;

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_instret", instret, 0);
    check("async_rst_halted", halted, 0);
    #1 rst = 1'b0;

    // resume is ignored in RUN.
    resume = 1'b1;
    step(); check("resume_in_run", pc, 4);
    resume = 1'b0;
    step(); step(); check("seq_0c", pc, 32'h0C);

    // Misaligned branch target traps.
    sel = 2'b01; offset = 32'd6;
    #1 check("trap_next_pc", next_pc, 32'h100);
    step();
    check("trap_flag", trap, 1);
    check("trap_vector", pc, 32'h100);
    check("trap_pc", trap_pc, 32'h0C);
    check("trap_instret", instret, 3);
    stall = 1'b1; sel = 2'b00;
    step(); check("trap_hold", pc, 32'h100);
    stall = 1'b0; resume = 1'b1;
    #1 check("resume_next_pc", next_pc, 0);
    step();
    check("resume_pc", pc, 0);
    check("resume_trap", trap, 0);
    check("resume_trap_pc_kept", trap_pc, 32'h0C);
    check("resume_instret_kept", instret, 3);
    resume = 1'b0;

    // Sequential fetch parks at HALT_ADDR.
    for (int i = 0; i < 12; i++) step();
    check("reach_48", pc, 48);
    check("reach_48_halted", halted, 0);
    check("instret_15", instret, 15);
    #1 check("halt_next_pc", next_pc, 48);
    step();
    check("halted", halted, 1);
    check("halt_pc", pc, 48);
    branch_taken = 1'b1; offset = 32'd8;
    for (int i = 0; i < 10; i++) begin
      step(); check("halt_hold", pc, 48);
    end
    check("halt_instret", instret, 15);
    branch_taken = 1'b0; resume = 1'b1;
    step();
    check("halt_resume_pc", pc, 0);
    check("halt_resume_flag", halted, 0);
    resume = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("reach_48_again", pc, 48);
    branch_taken = 1'b1; offset = 32'd8;
    step();
    check("branch_past_halt", pc, 56);
    check("branch_no_halt", halted, 0);
    check("instret_28", instret, 28);
    branch_taken = 1'b0;

    // Wrap-around and saturating counter on the second instance.
    #2 rst_b = 1'b0;
    step(); check("b_f4", pc_b, 32'hFFFF_FFF4);
    step(); step(); check("b_fc", pc_b, 32'hFFFF_FFFC);
    #1 check("b_wrap_next_pc", next_pc_b, 0);
    step();
    check("b_wrap_pc", pc_b, 0);
    check("b_instret_4", instret_b, 4);
    step(); step(); step();
    check("b_instret_7", instret_b, 7);
    step();
    check("b_instret_sat", instret_b, 7);
    check("b_pc_10", pc_b, 32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
